gene_sweep_ctrl: RTL and testbench
==================================

Name: gene_sweep_ctrl

Overview:
- Sequencer for exhaustive gene-network exploration.
- Drives every nonzero initial state (1 .. 2^WIDTH-1) into gene_net.
- Watches the fixed-point and cycle checker flags, classifies each trajectory and reports one result per initial state.
- Keeps running counts per class.
- Replaces free-running initial-value stepping with a start/busy/done controlled sweep.

Parameters:
- WIDTH, 8, width of the network state and initial value.
- MAX_STEPS, 64, run cycles per trajectory before a timeout is declared (2..255).
- SETTLE, 1, cycles after load during which checker flags are ignored.
- CNT_W, WIDTH+1, width of the class counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins a sweep when idle or done
- init_val_out  out  WIDTH  initial value presented to gene_net and the checkers
- load  out  1  one-cycle strobe; the network reloads from init_val_out
- x_in  in  WIDTH  current network state
- fixed_in  in  1  fixed-point checker flag
- cycle_in  in  1  cycle checker flag
- busy  out  1  high from the start acceptance until DONE
- done  out  1  high in DONE until the next start
- res_valid  out  1  result strobe
- res_init  out  WIDTH  initial value of the reported trajectory
- res_kind  out  2  00 fixed, 01 cycle, 10 timeout
- res_steps  out  8  run cycles taken to detection
- res_attr  out  WIDTH  x_in captured at detection
- fixed_cnt  out  CNT_W  number of fixed results this sweep
- cycle_cnt  out  CNT_W  number of cycle results this sweep
- timeout_cnt  out  CNT_W  number of timeout results this sweep

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE.
  - All outputs 0, including init_val_out=0, load=0, res_*=0 and all counters.
  - Takes effect mid-sweep immediately; no result is emitted for the aborted trajectory.
- FSM states: IDLE, LOAD, RUN, REPORT, DONE.
- IDLE:
  - start=1 -> LOAD.
  - cur=1, counters cleared, busy=1 from the next cycle.
- LOAD:
  - load=1 for exactly one cycle, init_val_out=cur, step=0 -> RUN.
  - init_val_out holds cur through RUN and REPORT.
- RUN, each cycle step=step+1:
  - Flags are ignored while step < SETTLE.
  - Otherwise fixed_in -> kind 00; else cycle_in -> kind 01; else step==MAX_STEPS -> kind 10.
  - fixed_in wins when both flags are high in the same cycle.
  - On detection: capture res_init=cur, res_steps=step, res_attr=x_in -> REPORT.
- REPORT:
  - res_valid=1 for one cycle; the matching counter increments.
  - If cur==2^WIDTH-1 -> DONE, else cur=cur+1 -> LOAD.
  - res_* hold their values until the next REPORT.
- DONE:
  - busy=0, done=1, counters hold.
  - start -> LOAD with cur=1, counters cleared, done=0.
- start is ignored while busy.
- Latency:
  - Per trajectory: 1 (LOAD) + step + 1 (REPORT) cycles.
  - Minimum 3 cycles per trajectory when SETTLE=1.
- Arithmetic:
  - Counters are CNT_W wide and saturate at their maximum; 2^WIDTH-1 results never saturate at the default width.
  - step saturates at 255.
- Invariant: fixed_cnt+cycle_cnt+timeout_cnt equals 2^WIDTH-1 in DONE.

Optional Feature:
- Macro: GENE_SWEEP_STALL_EN.
- Defined:
  - Adds input res_ready (1 bit).
  - REPORT holds res_valid=1 with stable res_* until res_ready=1.
  - The counter increments and the state advances only on the cycle where res_valid & res_ready.
- Undefined:
  - No res_ready port.
  - REPORT always lasts one cycle and the consumer must accept every strobe.

Decomposition:
- Package gene_sweep_pkg holds:
  - the state encoding typedef;
  - kind codes KIND_FIXED=2'b00, KIND_CYCLE=2'b01, KIND_TIMEOUT=2'b10;
  - the step counter width constant.
- One sub-module, gene_sweep_stats: the three saturating counters with clear and increment-by-kind inputs.

Test Plan:
- Identity network (next x = x), WIDTH=8, SETTLE=1:
  - 255 results, all kind 00, res_steps=1, res_attr=res_init.
  - fixed_cnt=255, others 0, done after 765 cycles.
- Rotate-left network with an ideal cycle checker:
  - init 8'h01 -> kind 01.
  - All 255 results are cycles; cycle_cnt=255.
- Both checker flags tied low, MAX_STEPS=4:
  - every result kind 10, res_steps=4; timeout_cnt=255.
- fixed_in and cycle_in forced high together on init 8'h05:
  - res_kind=00; fixed_cnt increments, cycle_cnt does not.
- rst_n pulsed low during RUN at cur=8'h10:
  - all outputs return to 0 asynchronously with no res_valid.
  - a following start restarts at init 8'h01 with counters at 0.
- GENE_SWEEP_STALL_EN defined, res_ready held low for 5 cycles at the first REPORT:
  - res_valid and res_init=8'h01 stable for 5 cycles, no second load.
  - counter increments once on the res_ready cycle.

Source files
------------

// File: rtl/gene_sweep_pkg.sv
// Shared types and constants for the gene-network sweep controller.
//   state_e      : controller FSM encoding
//   KIND_*       : result classification codes carried on res_kind
//   StepW/step_t : width/type of the per-trajectory run-cycle counter
package gene_sweep_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StReport,
    StDone
  } state_e;

  localparam logic [1:0] KIND_FIXED   = 2'b00;
  localparam logic [1:0] KIND_CYCLE   = 2'b01;
  localparam logic [1:0] KIND_TIMEOUT = 2'b10;

  localparam int unsigned StepW = 8;
  typedef logic [StepW-1:0] step_t;

endpackage

// File: rtl/gene_sweep_ctrl_if.sv
// Bundle of all non-clock/reset signals between the sweep controller and its
// environment (gene_net, fixed/cycle checkers, result consumer, host).
//   master : the controller side (drives init_val_out/load/status/results)
//   slave  : the environment side (drives start, x_in, checker flags)
// Optional macro GENE_SWEEP_STALL_EN adds res_ready (consumer backpressure).
interface gene_sweep_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = WIDTH + 1
);

  logic                      start;
  logic [WIDTH-1:0]          init_val_out;
  logic                      load;
  logic [WIDTH-1:0]          x_in;
  logic                      fixed_in;
  logic                      cycle_in;
  logic                      busy;
  logic                      done;
  logic                      res_valid;
  logic [WIDTH-1:0]          res_init;
  logic [1:0]                res_kind;
  gene_sweep_pkg::step_t     res_steps;
  logic [WIDTH-1:0]          res_attr;
  logic [CNT_W-1:0]          fixed_cnt;
  logic [CNT_W-1:0]          cycle_cnt;
  logic [CNT_W-1:0]          timeout_cnt;
`ifdef GENE_SWEEP_STALL_EN
  logic                      res_ready;
`endif

  modport master (
    input  start, x_in, fixed_in, cycle_in,
`ifdef GENE_SWEEP_STALL_EN
    input  res_ready,
`endif
    output init_val_out, load, busy, done,
    output res_valid, res_init, res_kind, res_steps, res_attr,
    output fixed_cnt, cycle_cnt, timeout_cnt
  );

  modport slave (
    output start, x_in, fixed_in, cycle_in,
`ifdef GENE_SWEEP_STALL_EN
    output res_ready,
`endif
    input  init_val_out, load, busy, done,
    input  res_valid, res_init, res_kind, res_steps, res_attr,
    input  fixed_cnt, cycle_cnt, timeout_cnt
  );

endinterface

// File: rtl/gene_sweep_stats.sv
// Three saturating per-class result counters for the sweep controller.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : zero all counters (start of a sweep)
//   inc, kind    : bump the counter selected by kind (KIND_* code)
//   fixed_cnt, cycle_cnt, timeout_cnt : running counts
module gene_sweep_stats
  import gene_sweep_pkg::*;
#(
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [1:0]       kind,
  output logic [CNT_W-1:0] fixed_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  logic [CNT_W-1:0] fixed_q, fixed_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    fixed_d   = fixed_q;
    cycle_d   = cycle_q;
    timeout_d = timeout_q;
    if (clear) begin
      fixed_d   = '0;
      cycle_d   = '0;
      timeout_d = '0;
    end else if (inc) begin
      unique case (kind)
        KIND_FIXED:   fixed_d   = sat_inc(fixed_q);
        KIND_CYCLE:   cycle_d   = sat_inc(cycle_q);
        KIND_TIMEOUT: timeout_d = sat_inc(timeout_q);
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fixed_q   <= '0;
      cycle_q   <= '0;
      timeout_q <= '0;
    end else begin
      fixed_q   <= fixed_d;
      cycle_q   <= cycle_d;
      timeout_q <= timeout_d;
    end
  end

  assign fixed_cnt   = fixed_q;
  assign cycle_cnt   = cycle_q;
  assign timeout_cnt = timeout_q;

endmodule

// File: rtl/gene_sweep_ctrl.sv
// Exhaustive sweep sequencer for a gene network. On start it loads every
// nonzero initial state 1 .. 2^WIDTH-1 into the network in turn, runs it until
// the fixed-point or cycle checker fires (or MAX_STEPS elapse), reports one
// classified result per initial state and keeps per-class counts.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : gene_sweep_ctrl_if.master -- start/busy/done, network load
//                and state, checker flags, result strobe and class counters
// Optional macro GENE_SWEEP_STALL_EN: REPORT waits for bus.res_ready.
module gene_sweep_ctrl
  import gene_sweep_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_STEPS = 64,
  parameter int unsigned SETTLE    = 1,
  parameter int unsigned CNT_W     = WIDTH + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  gene_sweep_ctrl_if.master  bus
);

  localparam step_t MaxSteps = step_t'(MAX_STEPS);
  localparam step_t SettleSt = step_t'(SETTLE);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  step_t            step_q, step_d;
  step_t            step_inc;
  logic [WIDTH-1:0] res_init_q, res_init_d;
  logic [WIDTH-1:0] res_attr_q, res_attr_d;
  logic [1:0]       res_kind_q, res_kind_d;
  step_t            res_steps_q, res_steps_d;
  logic             det;
  logic [1:0]       det_kind;
  logic             accept;
  logic             cnt_clear;
  logic             cnt_inc;

`ifdef GENE_SWEEP_STALL_EN
  assign accept = bus.res_ready;
`else
  assign accept = 1'b1;
`endif

  assign step_inc = (step_q == '1) ? step_q : step_q + step_t'(1);

  // Classification of the current RUN cycle; fixed beats cycle beats timeout.
  always_comb begin
    det      = 1'b0;
    det_kind = KIND_TIMEOUT;
    if (step_inc >= SettleSt) begin
      if (bus.fixed_in) begin
        det      = 1'b1;
        det_kind = KIND_FIXED;
      end else if (bus.cycle_in) begin
        det      = 1'b1;
        det_kind = KIND_CYCLE;
      end else if (step_inc == MaxSteps) begin
        det      = 1'b1;
        det_kind = KIND_TIMEOUT;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    step_d      = step_q;
    res_init_d  = res_init_q;
    res_attr_d  = res_attr_q;
    res_kind_d  = res_kind_q;
    res_steps_d = res_steps_q;
    cnt_clear   = 1'b0;
    cnt_inc     = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d   = StLoad;
          cur_d     = WIDTH'(1);
          cnt_clear = 1'b1;
        end
      end
      StLoad: begin
        step_d  = '0;
        state_d = StRun;
      end
      StRun: begin
        step_d = step_inc;
        if (det) begin
          res_init_d  = cur_q;
          res_attr_d  = bus.x_in;
          res_kind_d  = det_kind;
          res_steps_d = step_inc;
          state_d     = StReport;
        end
      end
      StReport: begin
        if (accept) begin
          cnt_inc = 1'b1;
          if (cur_q == '1) begin
            state_d = StDone;
          end else begin
            cur_d   = cur_q + WIDTH'(1);
            state_d = StLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      step_q      <= '0;
      res_init_q  <= '0;
      res_attr_q  <= '0;
      res_kind_q  <= '0;
      res_steps_q <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      step_q      <= step_d;
      res_init_q  <= res_init_d;
      res_attr_q  <= res_attr_d;
      res_kind_q  <= res_kind_d;
      res_steps_q <= res_steps_d;
    end
  end

  // cur_q is 0 out of reset and holds the trajectory's initial value from
  // LOAD through REPORT, so it drives the network directly.
  assign bus.init_val_out = cur_q;
  assign bus.load         = (state_q == StLoad);
  assign bus.busy         = (state_q == StLoad) || (state_q == StRun) || (state_q == StReport);
  assign bus.done         = (state_q == StDone);
  assign bus.res_valid    = (state_q == StReport);
  assign bus.res_init     = res_init_q;
  assign bus.res_attr     = res_attr_q;
  assign bus.res_kind     = res_kind_q;
  assign bus.res_steps    = res_steps_q;

  gene_sweep_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (cnt_clear),
    .inc         (cnt_inc),
    .kind        (res_kind_q),
    .fixed_cnt   (bus.fixed_cnt),
    .cycle_cnt   (bus.cycle_cnt),
    .timeout_cnt (bus.timeout_cnt)
  );

endmodule

// File: tb/tb_gene_sweep_ctrl.sv
// Self-checking bench for gene_sweep_ctrl. A behavioural network (identity,
// rotate-left, random map) with ideal checkers drives the DUT; expected
// results per initial state come from a trajectory model in plain loops.
module tb_gene_sweep_ctrl;

  localparam int W    = 8;
  localparam int MAXS = 4;
  localparam int SETL = 1;
  localparam int CW   = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gene_sweep_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  gene_sweep_ctrl #(
    .WIDTH     (W),
    .MAX_STEPS (MAXS),
    .SETTLE    (SETL),
    .CNT_W     (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // 0 identity, 1 rotate-left (no fixed checker), 2 random map, 3 rotate, flags low
  int       mode = 0;
  bit       f5_en = 1'b0;
  logic [7:0] tbl [256];
  bit       per [256];
  logic [7:0] x_q;

  function automatic logic [7:0] f(input logic [7:0] x);
    case (mode)
      0:       return x;
      2:       return tbl[x];
      default: return {x[6:0], x[7]};
    endcase
  endfunction

  function automatic logic fix_flag(input logic [7:0] x, input logic [7:0] ini);
    if (f5_en && ini == 8'h05) return 1'b1;
    if (mode == 1 || mode == 3) return 1'b0;
    return f(x) == x;
  endfunction

  function automatic logic cyc_flag(input logic [7:0] x, input logic [7:0] ini);
    if (f5_en && ini == 8'h05) return 1'b1;
    if (mode == 3) return 1'b0;
    return per[x];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        x_q <= '0;
    else if (bus.load) x_q <= bus.init_val_out;
    else               x_q <= f(x_q);
  end

  assign bus.x_in     = x_q;
  assign bus.fixed_in = fix_flag(x_q, bus.init_val_out);
  assign bus.cycle_in = cyc_flag(x_q, bus.init_val_out);

  logic [25:0] exp_q [$];
  int e_fix, e_cyc, e_to, e_cycles;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ctrl_vec();
    return 64'({bus.busy, bus.done, bus.load, bus.res_valid, bus.init_val_out});
  endfunction

  function automatic logic [63:0] res_vec();
    return 64'({bus.res_init, bus.res_kind, bus.res_steps, bus.res_attr});
  endfunction

  function automatic logic [63:0] cnt_vec();
    return 64'({bus.fixed_cnt, bus.cycle_cnt, bus.timeout_cnt});
  endfunction

  task automatic setup(input int m, input bit f5);
    mode  = m;
    f5_en = f5;
    if (m == 2) begin
      for (int i = 0; i < 256; i++)
        tbl[i] = ($urandom_range(0, 3) == 0) ? 8'(i) : 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < 256; i++) begin
      logic [7:0] y;
      y = f(8'(i));
      per[i] = 1'b0;
      for (int k = 0; k < 256; k++) begin
        if (y == 8'(i)) per[i] = 1'b1;
        y = f(y);
      end
    end
  endtask

  // Trajectory model: run cycle s sees x = f^(s-1)(init).
  task automatic build_model();
    exp_q.delete();
    e_fix = 0; e_cyc = 0; e_to = 0; e_cycles = 0;
    for (int i = 1; i < 256; i++) begin
      logic [7:0] x, ini;
      int k, s;
      x = 8'(i); ini = 8'(i); k = -1;
      for (s = 1; s <= 255; s++) begin
        if (s >= SETL) begin
          if (fix_flag(x, ini))      k = 0;
          else if (cyc_flag(x, ini)) k = 1;
          else if (s == MAXS)        k = 2;
        end
        if (k >= 0) break;
        x = f(x);
      end
      exp_q.push_back({ini, 2'(k), 8'(s), x});
      if (k == 0) e_fix++; else if (k == 1) e_cyc++; else e_to++;
      e_cycles += 2 + s;
    end
  endtask

  task automatic start_pulse();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic do_sweep(input int m, input bit f5);
    int edges, loads;
    bit fin;
    logic [25:0] e;
    setup(m, f5);
    build_model();
    start_pulse();
    chk("start_ctrl", ctrl_vec(), 64'({4'b1010, 8'h01}));
    chk("start_cnt", cnt_vec(), 64'd0);
    edges = 0; loads = 1; fin = 1'b0;
    for (int i = 0; i < 4000 && !fin; i++) begin
      bus.start = (i == 100);  // must be ignored while busy
      @(negedge clk);
      edges++;
      if (bus.load) loads++;
      if (bus.res_valid) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        chk("result", res_vec(), 64'(e));
      end
      if (bus.done) fin = 1'b1;
    end
    bus.start = 1'b0;
    chk("sweep_done", 64'(fin), 64'd1);
    chk("sweep_cycles", 64'(edges), 64'(e_cycles));
    chk("load_count", 64'(loads), 64'd255);
    chk("final_cnt", cnt_vec(), 64'({9'(e_fix), 9'(e_cyc), 9'(e_to)}));
    chk("cnt_sum", 64'(bus.fixed_cnt + bus.cycle_cnt + bus.timeout_cnt), 64'd255);
    chk("done_ctrl", 64'({bus.busy, bus.done, bus.load, bus.res_valid}), 64'b0100);
    chk("results_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    bit found;
    bus.start = 1'b0;
`ifdef GENE_SWEEP_STALL_EN
    bus.res_ready = 1'b1;
`endif
    #1;
    chk("reset_ctrl", ctrl_vec(), 64'd0);
    chk("reset_res", res_vec(), 64'd0);
    chk("reset_cnt", cnt_vec(), 64'd0);
    @(negedge clk); #2 rst_n = 1'b1;

    do_sweep(0, 1'b0);  // identity: all fixed, 765 cycles
    do_sweep(1, 1'b0);  // rotate: all cycles
    do_sweep(3, 1'b1);  // flags low: timeouts, init 5 both flags -> fixed
    do_sweep(2, 1'b0);  // random map
    do_sweep(2, 1'b0);

    // Asynchronous reset in RUN at cur 0x10.
    setup(3, 1'b0);
    start_pulse();
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (bus.init_val_out == 8'h10 && bus.busy && !bus.load && !bus.res_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("reach_run_10", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ctrl", ctrl_vec(), 64'd0);
    chk("abort_res", res_vec(), 64'd0);
    chk("abort_cnt", cnt_vec(), 64'd0);
    @(negedge clk);
    chk("abort_hold", ctrl_vec(), 64'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_abort_idle", ctrl_vec(), 64'd0);
    end
    do_sweep(3, 1'b0);

`ifdef GENE_SWEEP_STALL_EN
    setup(0, 1'b0);
    bus.res_ready = 1'b0;
    start_pulse();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.res_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("stall_reach", 64'(found), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", 64'({bus.res_valid, bus.load, bus.res_init, bus.fixed_cnt}),
          64'({1'b1, 1'b0, 8'h01, 9'd0}));
      if (i < 4) @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", 64'({bus.res_valid, bus.load, bus.init_val_out, bus.fixed_cnt}),
        64'({1'b0, 1'b1, 8'h02, 9'd1}));
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
